// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// ----------------
// Top-level sequencer for the Flappy Bird game. It owns the IDLE/PLAY/LOST
// state and generates the physics tick. It scrolls two pipes whose gap heights
// come from an 8-bit LFSR, detects collisions and keeps a saturating score.
// The bird-motion FSM is gated through BirdRun/BirdStart, and its position
// comes back on XBird/YBird.
//
// Ports
//   Clk                  single clock
//   Reset                asynchronous, active-high
//   Start                level input: begins a game, and leaves LOST
//   XBird, YBird         bird top-left corner (10 bit each)
//   BirdRun              high while in PLAY
//   BirdStart            one-cycle pulse in the first PLAY cycle
//   Tick                 one-cycle physics pulse (PLAY and LOST only)
//   Pipe0X, Pipe1X       pipe left edges
//   Pipe0GapY, Pipe1GapY pipe gap top edges
//   Score                pipes passed, saturating at 255
//   q_Idle/q_Play/q_Lost one-hot state view (debug and board LEDs)
//
// Interface note: there are no valid/ready handshakes on this block. Start is
// a level. Tick is a strobe that the bird FSM samples on the same edge as this
// block.
//
// Every output comes straight from a flop.

module flappy_game_ctrl #(
  parameter int TICK_DIV     = 2000000,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PIPE_SPACING = 320,
  parameter int PIPE_W       = 40,
  parameter int GAP_H        = 120,
  parameter int BIRD_SIZE    = 16,
  parameter int PIPE_SPEED   = 2,
  parameter int LOST_TICKS   = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] XBird,
  input  logic [9:0] YBird,
  output logic       BirdRun,
  output logic       BirdStart,
  output logic       Tick,
  output logic [9:0] Pipe0X,
  output logic [9:0] Pipe1X,
  output logic [9:0] Pipe0GapY,
  output logic [9:0] Pipe1GapY,
  output logic [7:0] Score,
  output logic       q_Idle,
  output logic       q_Play,
  output logic       q_Lost
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LCW = $clog2(LOST_TICKS + 1);

  localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
  localparam logic [LCW-1:0] LOST_MAX   = LCW'(LOST_TICKS);

  localparam logic [9:0]  PIPE0_RST = 10'(SCREEN_W);
  localparam logic [9:0]  PIPE1_RST = 10'(SCREEN_W + PIPE_SPACING);
  localparam logic [9:0]  GAP_RST   = 10'd180;
  localparam logic [9:0]  GAP_BASE  = 10'd60;
  localparam logic [7:0]  LFSR_RST  = 8'hA5;

  localparam logic [10:0] SCR_H11   = 11'(SCREEN_H);
  localparam logic [10:0] BIRD11    = 11'(BIRD_SIZE);
  localparam logic [10:0] PIPEW11   = 11'(PIPE_W);
  localparam logic [10:0] GAPH11    = 11'(GAP_H);
  localparam logic [10:0] SPEED11   = 11'(PIPE_SPEED);
  localparam logic [10:0] WRAP11    = 11'(2 * PIPE_SPACING - PIPE_SPEED);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_LOST = 2'd2
  } state_t;

  state_t          state_q, state_d;

  logic [TCW-1:0]  tick_cnt_q;
  logic            tick_q;
  logic [LCW-1:0]  lost_cnt_q;
  logic            armed_q;
  logic [7:0]      lfsr_q;
  logic [9:0]      pipe0x_q, pipe1x_q;
  logic [9:0]      gap0_q, gap1_q;
  logic [7:0]      score_q;

  logic            bird_run_q, bird_start_q;
  logic            q_idle_q, q_play_q, q_lost_q;

  // ---------------------------------------------------------------------------
  // Per-tick datapath. All of it uses 11-bit sums so that XBird+BIRD_SIZE and
  // PipeX+PIPE_W cannot wrap.
  // ---------------------------------------------------------------------------
  logic [10:0] xb, yb;
  logic        floor_hit, ceil_hit, hit0, hit1, collide;
  logic [9:0]  pipe0x_n, pipe1x_n;
  logic        respawn0, respawn1;
  logic        pass0, pass1;
  logic [8:0]  score_sum;
  logic [7:0]  score_n;
  logic        lost_exit;

  function automatic logic pipe_hit(input logic [10:0] bx, input logic [10:0] by,
                                    input logic [9:0] px, input logic [9:0] gy);
    logic [10:0] px11, gy11;
    px11 = {1'b0, px};
    gy11 = {1'b0, gy};
    return (bx + BIRD11 > px11) && (bx < px11 + PIPE_W11_f()) &&
           ((by < gy11) || (by + BIRD11 > gy11 + GAPH11));
  endfunction

  function automatic logic [10:0] PIPE_W11_f();
    return PIPEW11;
  endfunction

  // Moves a pipe left by one step. A pipe at or inside the left edge jumps
  // two spacings to the right, which puts it one spacing behind its partner.
  function automatic logic [9:0] step_x(input logic [9:0] px);
    logic [10:0] px11;
    px11 = {1'b0, px};
    if (px11 <= SPEED11) return 10'(px11 + WRAP11);
    else                 return 10'(px11 - SPEED11);
  endfunction

  // The trailing edge crosses the bird's left edge on this tick.
  function automatic logic passed(input logic [10:0] bx, input logic [9:0] old_x,
                                  input logic [9:0] new_x);
    return ({1'b0, old_x} + PIPEW11 > bx) && ({1'b0, new_x} + PIPEW11 <= bx);
  endfunction

  always_comb begin
    xb        = {1'b0, XBird};
    yb        = {1'b0, YBird};
    floor_hit = (yb + BIRD11 >= SCR_H11);
    // If the bird flies above row 0, its 10-bit Y wraps to a large value.
    ceil_hit  = (yb >= SCR_H11);
    hit0      = pipe_hit(xb, yb, pipe0x_q, gap0_q);
    hit1      = pipe_hit(xb, yb, pipe1x_q, gap1_q);
    collide   = floor_hit | ceil_hit | hit0 | hit1;

    respawn0  = ({1'b0, pipe0x_q} <= SPEED11);
    respawn1  = ({1'b0, pipe1x_q} <= SPEED11);
    pipe0x_n  = step_x(pipe0x_q);
    pipe1x_n  = step_x(pipe1x_q);

    pass0     = passed(xb, pipe0x_q, pipe0x_n);
    pass1     = passed(xb, pipe1x_q, pipe1x_n);
    score_sum = {1'b0, score_q} + {8'd0, pass0} + {8'd0, pass1};
    score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];

    lost_exit = (lost_cnt_q == LOST_MAX) && armed_q && Start;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / registered-output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start)            state_d = S_PLAY;
      S_PLAY: if (tick_q && collide) state_d = S_LOST;
      S_LOST: if (lost_exit)        state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // The outputs are decoded from the next state and then registered, so the
  // output flops always agree with state_q.
  logic bird_run_d, bird_start_d, q_idle_d, q_play_d, q_lost_d;

  always_comb begin
    q_idle_d     = (state_d == S_IDLE);
    q_play_d     = (state_d == S_PLAY);
    q_lost_d     = (state_d == S_LOST);
    bird_run_d   = (state_d == S_PLAY);
    bird_start_d = (state_q == S_IDLE) && (state_d == S_PLAY);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_idle_q     <= 1'b1;
      q_play_q     <= 1'b0;
      q_lost_q     <= 1'b0;
      bird_run_q   <= 1'b0;
      bird_start_q <= 1'b0;
    end else begin
      q_idle_q     <= q_idle_d;
      q_play_q     <= q_play_d;
      q_lost_q     <= q_lost_d;
      bird_run_q   <= bird_run_d;
      bird_start_q <= bird_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      lost_cnt_q <= '0;
      armed_q    <= 1'b0;
      lfsr_q     <= LFSR_RST;
      pipe0x_q   <= PIPE0_RST;
      pipe1x_q   <= PIPE1_RST;
      gap0_q     <= GAP_RST;
      gap1_q     <= GAP_RST;
      score_q    <= '0;
    end else begin
      // Taps 8,6,5,4. The LFSR free-runs in every state, so the gap sequence
      // depends on how long the player waited before starting.
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

      case (state_q)
        S_PLAY, S_LOST: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b1;
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            tick_q     <= 1'b0;
          end

          if (state_q == S_PLAY) begin
            if (tick_q) begin
              if (collide) begin
                // Freeze the playfield. The LOST bookkeeping starts from zero.
                lost_cnt_q <= '0;
                armed_q    <= 1'b0;
              end else begin
                pipe0x_q <= pipe0x_n;
                pipe1x_q <= pipe1x_n;
                if (respawn0) gap0_q <= GAP_BASE + {2'b00, lfsr_q};
                if (respawn1) gap1_q <= GAP_BASE + {2'b00, lfsr_q};
                score_q  <= score_n;
              end
            end
          end else begin
            if (tick_q && (lost_cnt_q != LOST_MAX)) lost_cnt_q <= lost_cnt_q + 1'b1;
            // A Start held from the previous game must be released before it
            // counts again.
            if (!Start) armed_q <= 1'b1;
            if (lost_exit) begin
              tick_cnt_q <= '0;
              tick_q     <= 1'b0;
              lost_cnt_q <= '0;
              armed_q    <= 1'b0;
              pipe0x_q   <= PIPE0_RST;
              pipe1x_q   <= PIPE1_RST;
              gap0_q     <= GAP_RST;
              gap1_q     <= GAP_RST;
              score_q    <= '0;
            end
          end
        end
        default: begin
          // IDLE, and any illegal encoding. The playfield is held at its reset
          // values, so entering PLAY needs no extra clearing.
          tick_cnt_q <= '0;
          tick_q     <= 1'b0;
          lost_cnt_q <= '0;
          armed_q    <= 1'b0;
          pipe0x_q   <= PIPE0_RST;
          pipe1x_q   <= PIPE1_RST;
          gap0_q     <= GAP_RST;
          gap1_q     <= GAP_RST;
          score_q    <= '0;
        end
      endcase
    end
  end

  assign BirdRun   = bird_run_q;
  assign BirdStart = bird_start_q;
  assign Tick      = tick_q;
  assign Pipe0X    = pipe0x_q;
  assign Pipe1X    = pipe1x_q;
  assign Pipe0GapY = gap0_q;
  assign Pipe1GapY = gap1_q;
  assign Score     = score_q;
  assign q_Idle    = q_idle_q;
  assign q_Play    = q_play_q;
  assign q_Lost    = q_lost_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed testbench for flappy_game_ctrl, using TICK_DIV=4 and LOST_TICKS=2.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same
// point.

module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] xbird = 10'd500;
  logic [9:0] ybird = 10'd100;

  logic       bird_run, bird_start, tick;
  logic [9:0] pipe0x, pipe1x, gap0, gap1;
  logic [7:0] score;
  logic       q_idle, q_play, q_lost;

  int tests = 0;
  int fails = 0;

  flappy_game_ctrl #(
    .TICK_DIV  (4),
    .LOST_TICKS(2)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .Start    (start),
    .XBird    (xbird),
    .YBird    (ybird),
    .BirdRun  (bird_run),
    .BirdStart(bird_start),
    .Tick     (tick),
    .Pipe0X   (pipe0x),
    .Pipe1X   (pipe1x),
    .Pipe0GapY(gap0),
    .Pipe1GapY(gap1),
    .Score    (score),
    .q_Idle   (q_idle),
    .q_Play   (q_play),
    .q_Lost   (q_lost)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Reference LFSR (taps 8,6,5,4), used to predict the respawned gap heights.
  function automatic logic [7:0] next_lfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= next_lfsr(lfsr_m);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until Tick is visible, up to a fixed budget. n is the number of
  // steps taken.
  task automatic wait_tick(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n++;
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    check("tick_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic run_ticks(input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      wait_tick(n);
      step();
    end
  endtask

  int n;
  logic [9:0] exp_gap;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle",  {31'd0, q_idle}, 32'd1);
    check("rst_play",  {31'd0, q_play}, 32'd0);
    check("rst_lost",  {31'd0, q_lost}, 32'd0);
    check("rst_run",   {31'd0, bird_run}, 32'd0);
    check("rst_tick",  {31'd0, tick}, 32'd0);
    check("rst_score", {24'd0, score}, 32'd0);
    check("rst_p0x",   {22'd0, pipe0x}, 32'd640);
    check("rst_p1x",   {22'd0, pipe1x}, 32'd960);
    check("rst_gap0",  {22'd0, gap0}, 32'd180);
    check("rst_gap1",  {22'd0, gap1}, 32'd180);
    rst = 1'b0;
    step();
    check("idle_hold", {31'd0, q_idle}, 32'd1);

    // ---------------- start and scroll ----------------
    start = 1'b1;
    step();
    check("start_play",   {31'd0, q_play}, 32'd1);
    check("start_pulse",  {31'd0, bird_start}, 32'd1);
    check("start_run",    {31'd0, bird_run}, 32'd1);
    start = 1'b0;
    step();
    check("start_pulse_end", {31'd0, bird_start}, 32'd0);
    wait_tick(n);
    check("first_tick_lat", n, 32'd3);
    check("p0x_pre_tick", {22'd0, pipe0x}, 32'd640);
    step();
    check("tick_one_cycle", {31'd0, tick}, 32'd0);
    check("p0x_638", {22'd0, pipe0x}, 32'd638);
    wait_tick(n);
    check("tick_period", n, 32'd3);
    step();
    check("p0x_636", {22'd0, pipe0x}, 32'd636);
    check("p1x_956", {22'd0, pipe1x}, 32'd956);
    check("score_0", {24'd0, score}, 32'd0);

    // Floor boundary: 463+16 = 479 is still clear of the floor.
    ybird = 10'd463;
    run_ticks(1);
    check("floor_463_play", {31'd0, q_play}, 32'd1);
    check("p0x_634", {22'd0, pipe0x}, 32'd634);

    // ---------------- floor collision ----------------
    ybird = 10'd464;
    wait_tick(n);
    step();
    check("floor_lost", {31'd0, q_lost}, 32'd1);
    check("floor_run",  {31'd0, bird_run}, 32'd0);
    check("floor_p0x_frozen", {22'd0, pipe0x}, 32'd634);
    // Start was low, so armed sets on the next edge. Start is then raised
    // early, and the exit still waits for two LOST ticks.
    step();
    start = 1'b1;
    run_ticks(1);
    check("lost_after_1", {31'd0, q_lost}, 32'd1);
    run_ticks(1);
    check("lost_after_2", {31'd0, q_lost}, 32'd1);
    check("lost_p0x_frozen", {22'd0, pipe0x}, 32'd634);
    step();
    check("lost_exit_idle", {31'd0, q_idle}, 32'd1);
    check("exit_score", {24'd0, score}, 32'd0);
    check("exit_p0x", {22'd0, pipe0x}, 32'd640);
    check("exit_p1x", {22'd0, pipe1x}, 32'd960);

    // ---------------- scoring / respawn / saturation ----------------
    xbird = 10'd100;
    ybird = 10'd200;
    step();   // Start is still high, so the game begins again.
    check("g2_play", {31'd0, q_play}, 32'd1);
    check("g2_pulse", {31'd0, bird_start}, 32'd1);
    run_ticks(289);
    check("g2_p0x_62", {22'd0, pipe0x}, 32'd62);
    check("g2_score_pre", {24'd0, score}, 32'd0);
    check("g2_still_play", {31'd0, q_play}, 32'd1);
    run_ticks(1);
    check("g2_p0x_60", {22'd0, pipe0x}, 32'd60);
    check("g2_score_1", {24'd0, score}, 32'd1);
    run_ticks(29);
    check("g2_p0x_2", {22'd0, pipe0x}, 32'd2);
    check("g2_score_hold", {24'd0, score}, 32'd1);
    wait_tick(n);
    exp_gap = 10'd60 + {2'b00, lfsr_m};
    step();
    check("respawn_p0x", {22'd0, pipe0x}, 32'd640);
    check("respawn_gap0", {22'd0, gap0}, {22'd0, exp_gap});
    check("respawn_p1x", {22'd0, pipe1x}, 32'd320);
    check("respawn_gap1", {22'd0, gap1}, 32'd180);

    force dut.score_q = 8'd255;
    #1;
    release dut.score_q;
    run_ticks(129);
    check("sat_p1x_62", {22'd0, pipe1x}, 32'd62);
    check("sat_pre", {24'd0, score}, 32'd255);
    run_ticks(1);
    check("sat_p1x_60", {22'd0, pipe1x}, 32'd60);
    check("sat_hold", {24'd0, score}, 32'd255);

    // ---------------- LOST exit with Start held ----------------
    ybird = 10'd464;
    run_ticks(1);
    check("g2_lost", {31'd0, q_lost}, 32'd1);
    check("g2_p1x_frozen", {22'd0, pipe1x}, 32'd60);
    check("g2_p0x_frozen", {22'd0, pipe0x}, 32'd380);
    run_ticks(3);
    check("held_start_lost", {31'd0, q_lost}, 32'd1);
    start = 1'b0;
    step();
    check("arm_lost", {31'd0, q_lost}, 32'd1);
    start = 1'b1;
    xbird = 10'd500;
    ybird = 10'd100;
    step();
    check("g2_exit_idle", {31'd0, q_idle}, 32'd1);
    check("g2_exit_score", {24'd0, score}, 32'd0);
    check("g2_exit_p0x", {22'd0, pipe0x}, 32'd640);
    check("g2_exit_p1x", {22'd0, pipe1x}, 32'd960);
    check("g2_exit_gap0", {22'd0, gap0}, 32'd180);

    // ---------------- async reset mid-PLAY ----------------
    step();
    check("g3_play", {31'd0, q_play}, 32'd1);
    start = 1'b0;
    run_ticks(1);
    check("g3_p0x_638", {22'd0, pipe0x}, 32'd638);
    wait_tick(n);
    rst = 1'b1;
    #1;
    check("arst_idle", {31'd0, q_idle}, 32'd1);
    check("arst_play", {31'd0, q_play}, 32'd0);
    check("arst_tick", {31'd0, tick}, 32'd0);
    check("arst_score", {24'd0, score}, 32'd0);
    check("arst_p0x", {22'd0, pipe0x}, 32'd640);
    check("arst_run", {31'd0, bird_run}, 32'd0);
    #2;
    rst = 1'b0;
    repeat (4) step();
    check("post_rst_idle", {31'd0, q_idle}, 32'd1);
    check("post_rst_tick", {31'd0, tick}, 32'd0);
    start = 1'b1;
    step();
    check("post_rst_play", {31'd0, q_play}, 32'd1);
    check("post_rst_pulse", {31'd0, bird_start}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
